// File: rtl/vpipe_stall_ctrl_if.sv
// Pipeline control bundle shared between the stall controller and the
// delay lines / issue logic it serves. The issue side (master) presents
// stall, flush and new-instruction requests; the controller (slave)
// answers with the per-register enable, clear and occupancy vectors.
interface vpipe_stall_ctrl_if #(
  parameter int NUMSTAGES = 32
);
  logic [NUMSTAGES-1:0] internal_stall;
  logic [NUMSTAGES-1:0] squash_req;
  logic                 in_valid;
  logic                 in_ready;
  logic [NUMSTAGES-1:0] en;
  logic [NUMSTAGES-1:0] squash;
  logic [NUMSTAGES-1:0] valid;

  modport master (
    output internal_stall,
    output squash_req,
    output in_valid,
    input  in_ready,
    input  en,
    input  squash,
    input  valid
  );

  modport slave (
    input  internal_stall,
    input  squash_req,
    input  in_valid,
    output in_ready,
    output en,
    output squash,
    output valid
  );
endinterface

// File: rtl/vpipe_stall_ctrl.sv
// Vector pipeline stall controller. Turns per-stage stall and flush
// requests into the hold / advance / bubble pattern for every delay line
// in the lane, tracks which pipe registers hold a live instruction, gates
// intake at stage 0, runs a drain sequence on request and counts the
// cycles in which stage 0 could not advance.
module vpipe_stall_ctrl #(
  parameter int NUMSTAGES = 32,
  parameter int CNTW      = 16
) (
  input  logic               clk,
  input  logic               reset,
  vpipe_stall_ctrl_if.slave  pipe,
  input  logic               drain_req,
  output logic               drained,
  output logic [CNTW-1:0]    stall_cycles,
  input  logic               stall_clr
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [NUMSTAGES-1:0] stalled;
  logic [NUMSTAGES-1:0] flush;
  logic [NUMSTAGES-1:0] en_c;
  logic [NUMSTAGES-1:0] squash_c;
  logic [NUMSTAGES-1:0] shift_in;
  logic                 in_ready_c;
  logic                 accept;

  logic [NUMSTAGES-1:0] valid_q, valid_d;
  logic [1:0]           state_q, state_d;
  logic [CNTW-1:0]      stall_cycles_q, stall_cycles_d;

  // A register is stalled when it or anything downstream of it is stuck;
  // a register is flushed when a flush resolves at it or further down.
  always_comb begin
    stalled = '0;
    flush   = '0;
    for (int i = 0; i < NUMSTAGES; i++) begin
      stalled[i] = |(pipe.internal_stall >> i);
      flush[i]   = |(pipe.squash_req >> i);
    end
  end

  // Per-register enables and clears; reset forces every register to clear
  // and blocks intake so the delay lines empty alongside the occupancy map.
  always_comb begin
    in_ready_c = ~stalled[0] & (state_q == ST_RUN) & ~flush[0] & ~reset;
    accept     = pipe.in_valid & in_ready_c;
    en_c       = ~stalled;
    squash_c   = '0;
    squash_c[0] = flush[0] | (~stalled[0] & ~accept);
    for (int i = 1; i < NUMSTAGES; i++) begin
      squash_c[i] = flush[i] | (stalled[i-1] & ~stalled[i]);
    end
    if (reset) begin
      en_c     = '0;
      squash_c = '1;
    end
  end

  assign pipe.en       = en_c;
  assign pipe.squash   = squash_c;
  assign pipe.in_ready = in_ready_c;
  assign pipe.valid    = valid_q;

  // Occupancy follows the same load/clear decisions as the delay lines:
  // a clear wins, otherwise an enabled register takes its upstream neighbour
  // (or the accepted instruction at stage 0), otherwise it holds.
  always_comb begin
    shift_in = {valid_q[NUMSTAGES-2:0], accept};
    valid_d  = ~squash_c & ((en_c & shift_in) | (~en_c & valid_q));
  end

  // Drain sequencing: stop intake, wait for the registered occupancy to
  // reach empty, then report drained until the request is withdrawn.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (drain_req)         state_d = ST_DRAIN;
      ST_DRAIN: if (valid_q == '0)     state_d = ST_DONE;
      ST_DONE:  if (!drain_req)        state_d = ST_RUN;
      default:                         state_d = ST_RUN;
    endcase
  end

  assign drained = (state_q == ST_DONE);

  // Saturating count of cycles where stage 0 was held; clear beats count.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_clr) begin
      stall_cycles_d = '0;
    end else if (stalled[0] && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  assign stall_cycles = stall_cycles_q;

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q        <= '0;
      state_q        <= ST_RUN;
      stall_cycles_q <= '0;
    end else begin
      valid_q        <= valid_d;
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_vpipe_stall_ctrl.sv
// Testbench for vpipe_stall_ctrl with a four-stage pipe and a two-bit
// stall counter: directed scenarios followed by randomized traffic
// checked against a stage-range model of the pipeline.
module tb_vpipe_stall_ctrl;
  localparam int N    = 4;
  localparam int CNTW = 2;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            clk;
  logic            reset;
  logic            drain_req;
  logic            drained;
  logic [CNTW-1:0] stall_cycles;
  logic            stall_clr;
  int              total;
  int              bad;

  vpipe_stall_ctrl_if #(.NUMSTAGES(N)) pif ();

  vpipe_stall_ctrl #(.NUMSTAGES(N), .CNTW(CNTW)) dut (
    .clk          (clk),
    .reset        (reset),
    .pipe         (pif),
    .drain_req    (drain_req),
    .drained      (drained),
    .stall_cycles (stall_cycles),
    .stall_clr    (stall_clr)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    pif.internal_stall = '0;
    pif.squash_req     = '0;
    pif.in_valid       = 1'b0;
    drain_req          = 1'b0;
    stall_clr          = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic fill_pipe();
    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      idle_inputs();
      pif.in_valid = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    total++; if (pif.en !== 4'b0000) begin bad++; $display("[TB] FAIL reset_en: got %b want 0000", pif.en); end
    total++; if (pif.squash !== 4'b1111) begin bad++; $display("[TB] FAIL reset_squash: got %b want 1111", pif.squash); end
    total++; if (pif.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 0", pif.in_ready); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (pif.valid !== 4'b0000) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0000", pif.valid); end
    total++; if (drained !== 1'b0) begin bad++; $display("[TB] FAIL reset_drained: got %b want 0", drained); end
    total++; if (stall_cycles !== 2'd0) begin bad++; $display("[TB] FAIL reset_cnt: got %0d want 0", stall_cycles); end
    total++; if (pif.en !== 4'b1111) begin bad++; $display("[TB] FAIL post_reset_en: got %b want 1111", pif.en); end
    total++; if (pif.squash !== 4'b0001) begin bad++; $display("[TB] FAIL post_reset_squash: got %b want 0001", pif.squash); end
  endtask

  task automatic test_single_issue();
    logic [N-1:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    @(negedge clk);
    idle_inputs();
    pif.in_valid = 1'b1;
    #1;
    total++; if (pif.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL single_ready: got %b want 1", pif.in_ready); end
    total++; if (pif.squash !== 4'b0000) begin bad++; $display("[TB] FAIL single_accept_squash: got %b want 0000", pif.squash); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      pif.in_valid = 1'b0;
      #1;
      total++; if (pif.valid !== seq[k]) begin bad++; $display("[TB] FAIL single_valid_%0d: got %b want %b", k, pif.valid, seq[k]); end
      total++; if (pif.en !== 4'b1111) begin bad++; $display("[TB] FAIL single_en_%0d: got %b want 1111", k, pif.en); end
      total++; if (pif.squash[0] !== 1'b1) begin bad++; $display("[TB] FAIL single_squash0_%0d: got %b want 1", k, pif.squash[0]); end
    end
  endtask

  task automatic test_stall_bubble();
    fill_pipe();
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      idle_inputs();
      pif.internal_stall = 4'b0010;
      pif.in_valid       = 1'b1;
      #1;
      if (c == 1) begin
        total++; if (pif.valid !== 4'b1111) begin bad++; $display("[TB] FAIL stall_full: got %b want 1111", pif.valid); end
      end else begin
        total++; if (pif.valid !== 4'b1011) begin bad++; $display("[TB] FAIL stall_valid_c1: got %b want 1011", pif.valid); end
        total++; if (stall_cycles !== 2'd1) begin bad++; $display("[TB] FAIL stall_cnt_c1: got %0d want 1", stall_cycles); end
      end
      total++; if (pif.en !== 4'b1100) begin bad++; $display("[TB] FAIL stall_en_c%0d: got %b want 1100", c, pif.en); end
      total++; if (pif.squash !== 4'b0100) begin bad++; $display("[TB] FAIL stall_squash_c%0d: got %b want 0100", c, pif.squash); end
      total++; if (pif.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_ready_c%0d: got %b want 0", c, pif.in_ready); end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    // Register 3 advanced again in cycle 2 and picked up the bubble left
    // in register 2 by cycle 1.
    total++; if (pif.valid !== 4'b0011) begin bad++; $display("[TB] FAIL stall_valid_c2: got %b want 0011", pif.valid); end
    total++; if (stall_cycles !== 2'd2) begin bad++; $display("[TB] FAIL stall_cnt_c2: got %0d want 2", stall_cycles); end
  endtask

  task automatic test_flush_with_stall();
    fill_pipe();
    @(negedge clk);
    idle_inputs();
    pif.squash_req     = 4'b0100;
    pif.internal_stall = 4'b0010;
    pif.in_valid       = 1'b1;
    #1;
    total++; if (pif.squash !== 4'b0111) begin bad++; $display("[TB] FAIL flush_squash: got %b want 0111", pif.squash); end
    total++; if (pif.en !== 4'b1100) begin bad++; $display("[TB] FAIL flush_en: got %b want 1100", pif.en); end
    total++; if (pif.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_ready: got %b want 0", pif.in_ready); end
    @(negedge clk);
    idle_inputs();
    #1;
    total++; if (pif.valid !== 4'b1000) begin bad++; $display("[TB] FAIL flush_valid: got %b want 1000", pif.valid); end
  endtask

  task automatic test_drain();
    logic [N-1:0] seq [4];
    seq = '{4'b1100, 4'b1000, 4'b0000, 4'b0000};
    do_reset();
    @(negedge clk); pif.in_valid = 1'b1;
    @(negedge clk); pif.in_valid = 1'b1;
    @(negedge clk); pif.in_valid = 1'b0;
    @(negedge clk);
    drain_req = 1'b1;
    #1;
    total++; if (pif.valid !== 4'b0110) begin bad++; $display("[TB] FAIL drain_start_valid: got %b want 0110", pif.valid); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pif.in_valid = 1'b1;
      #1;
      total++; if (pif.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL drain_ready_%0d: got %b want 0", k, pif.in_ready); end
      total++; if (pif.valid !== seq[k]) begin bad++; $display("[TB] FAIL drain_valid_%0d: got %b want %b", k, pif.valid, seq[k]); end
      total++; if (drained !== (k == 3)) begin bad++; $display("[TB] FAIL drain_drained_%0d: got %b want %b", k, drained, (k == 3)); end
    end
    @(negedge clk);
    pif.in_valid = 1'b0;
    drain_req    = 1'b0;
    #1;
    total++; if (drained !== 1'b1) begin bad++; $display("[TB] FAIL drain_hold: got %b want 1", drained); end
    @(negedge clk);
    #1;
    total++; if (drained !== 1'b0) begin bad++; $display("[TB] FAIL drain_exit: got %b want 0", drained); end
    total++; if (pif.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL drain_exit_ready: got %b want 1", pif.in_ready); end
  endtask

  task automatic test_counter_saturate();
    int want;
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      pif.internal_stall = (c < 5) ? 4'b0001 : 4'b0000;
      #1;
      want = (c < CMAX) ? c : CMAX;
      total++; if (stall_cycles !== CNTW'(want)) begin bad++; $display("[TB] FAIL cnt_%0d: got %0d want %0d", c, stall_cycles, want); end
    end
    @(negedge clk);
    pif.internal_stall = 4'b0001;
    stall_clr          = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    total++; if (stall_cycles !== 2'd0) begin bad++; $display("[TB] FAIL cnt_clr: got %0d want 0", stall_cycles); end
  endtask

  task automatic test_reset_mid_stall();
    fill_pipe();
    @(negedge clk);
    idle_inputs();
    pif.internal_stall = 4'b0100;
    pif.in_valid       = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (stall_cycles !== 2'd1) begin bad++; $display("[TB] FAIL rmid_cnt_before: got %0d want 1", stall_cycles); end
    total++; if (pif.en !== 4'b0000) begin bad++; $display("[TB] FAIL rmid_en: got %b want 0000", pif.en); end
    total++; if (pif.squash !== 4'b1111) begin bad++; $display("[TB] FAIL rmid_squash: got %b want 1111", pif.squash); end
    total++; if (pif.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rmid_ready: got %b want 0", pif.in_ready); end
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #1;
    total++; if (pif.valid !== 4'b0000) begin bad++; $display("[TB] FAIL rmid_valid: got %b want 0000", pif.valid); end
    total++; if (stall_cycles !== 2'd0) begin bad++; $display("[TB] FAIL rmid_cnt: got %0d want 0", stall_cycles); end
    total++; if (pif.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rmid_run_ready: got %b want 1", pif.in_ready); end
  endtask

  // Reference model: the deepest stalled stage s holds everything at or
  // below it and leaves a hole just above it, the deepest flush k wipes
  // everything at or below it, and the rest of the pipe shifts by one.
  task automatic test_random();
    logic [N-1:0] mv, nv, exp_en, exp_sq;
    int           mstate;
    int           mcnt;
    int           s, k;
    logic         exp_ready, acc;
    do_reset();
    mv = '0; mstate = 0; mcnt = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      reset     = ($urandom_range(63) == 0);
      for (int i = 0; i < N; i++) begin
        pif.internal_stall[i] = ($urandom_range(5) == 0);
        pif.squash_req[i]     = ($urandom_range(9) == 0);
      end
      pif.in_valid = ($urandom_range(3) != 0);
      if ($urandom_range(19) == 0) drain_req = ~drain_req;
      stall_clr = ($urandom_range(15) == 0);
      s = -1; k = -1;
      for (int i = 0; i < N; i++) begin
        if (pif.internal_stall[i]) s = i;
        if (pif.squash_req[i]) k = i;
      end
      exp_ready = !reset && (s < 0) && (k < 0) && (mstate == 0);
      acc       = pif.in_valid && exp_ready;
      for (int i = 0; i < N; i++) begin
        exp_en[i] = !reset && (i > s);
        exp_sq[i] = reset || (i <= k) || (s >= 0 && i == s + 1) || (i == 0 && s < 0 && !acc);
      end
      #1;
      total++; if (pif.en !== exp_en) begin bad++; $display("[TB] FAIL rnd_en@%0d: got %b want %b", cyc, pif.en, exp_en); end
      total++; if (pif.squash !== exp_sq) begin bad++; $display("[TB] FAIL rnd_squash@%0d: got %b want %b", cyc, pif.squash, exp_sq); end
      total++; if (pif.in_ready !== exp_ready) begin bad++; $display("[TB] FAIL rnd_ready@%0d: got %b want %b", cyc, pif.in_ready, exp_ready); end
      total++; if (pif.valid !== mv) begin bad++; $display("[TB] FAIL rnd_valid@%0d: got %b want %b", cyc, pif.valid, mv); end
      total++; if (drained !== (mstate == 2)) begin bad++; $display("[TB] FAIL rnd_drained@%0d: got %b want %b", cyc, drained, (mstate == 2)); end
      total++; if (stall_cycles !== CNTW'(mcnt)) begin bad++; $display("[TB] FAIL rnd_cnt@%0d: got %0d want %0d", cyc, stall_cycles, mcnt); end
      for (int i = 0; i < N; i++) begin
        if (i <= k)                  nv[i] = 1'b0;
        else if (i <= s)             nv[i] = mv[i];
        else if (s >= 0 && i == s+1) nv[i] = 1'b0;
        else if (i == 0)             nv[i] = acc;
        else                         nv[i] = mv[i-1];
      end
      if (reset) begin
        mstate = 0;
        mcnt   = 0;
        mv     = '0;
      end else begin
        case (mstate)
          0: if (drain_req) mstate = 1;
          1: if (mv == '0) mstate = 2;
          default: if (!drain_req) mstate = 0;
        endcase
        if (stall_clr) mcnt = 0;
        else if (s >= 0 && mcnt < CMAX) mcnt = mcnt + 1;
        mv = nv;
      end
    end
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle_inputs();
    $display("[TB] starting vpipe_stall_ctrl bench");
    test_reset();
    test_single_issue();
    test_stall_bubble();
    test_flush_with_stall();
    test_drain();
    test_counter_saturate();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
